// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the I/D memory-port arbiter.
// Line sizes, line-offset widths and the arbiter state encoding live here.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_XFER = 2'd1,
    D_XFER = 2'd2,
    DONE   = 2'd3
  } arb_state_e;

  localparam int ILINE_WORDS_DEF = 8;
  localparam int DLINE_WORDS_DEF = 4;
  localparam int IOFF_W          = 5;
  localparam int DOFF_W          = 4;
  localparam int BEAT_W          = 3;

  // Clear the byte-offset bits below a line boundary.
  function automatic logic [31:0] lineAlign(input logic [31:0] addr, input int offW);
    lineAlign = addr & ~((32'd1 << offW) - 32'd1);
  endfunction

endpackage

// File: rtl/burst_counter.sv
// Beat counter for one line burst: synchronous clear, gated increment,
// and a terminal-count flag that also stops the count from wrapping.
module burst_counter
  import mem_arb_pkg::*;
#(
  parameter int W = BEAT_W
) (
  input  logic         clk,
  input  logic         RST,
  input  logic         i_clear,
  input  logic         i_inc,
  input  logic [W-1:0] i_last,
  output logic [W-1:0] o_count,
  output logic         o_tc
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (RST) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_inc && !o_tc) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_tc    = (r_count == i_last);

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one backing-memory port between I-cache refills
// and D-cache refills/writebacks, one full line burst per grant.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ILINE_WORDS = ILINE_WORDS_DEF,
  parameter int DLINE_WORDS = DLINE_WORDS_DEF
) (
  input  logic        clk,
  input  logic        RST,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  output logic [2:0]  i_beat,
  output logic        i_done,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic        d_done,
  output logic [31:0] d_rdata,
  output logic [1:0]  d_beat,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  localparam logic [BEAT_W-1:0] I_LAST = BEAT_W'(ILINE_WORDS - 1);
  localparam logic [BEAT_W-1:0] D_LAST = BEAT_W'(DLINE_WORDS - 1);

  arb_state_e        r_state;
  arb_state_e        w_nextState;
  logic              r_lastD;
  logic              r_servedD;
  logic [31:0]       r_base;
  logic              w_grantI;
  logic              w_grantD;
  logic              w_xfer;
  logic              w_clear;
  logic              w_inc;
  logic              w_tc;
  logic [BEAT_W-1:0] w_count;
  logic [BEAT_W-1:0] w_last;

  always_ff @(posedge clk) begin
    if (RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // On a tie the side that was not served last wins.
  always_comb begin
    w_nextState = r_state;
    w_grantI    = 1'b0;
    w_grantD    = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_req && (!d_req || r_lastD)) begin
          w_grantI    = 1'b1;
          w_nextState = I_XFER;
        end else if (d_req) begin
          w_grantD    = 1'b1;
          w_nextState = D_XFER;
        end
      end
      I_XFER, D_XFER: begin
        if (mem_ready && w_tc) begin
          w_nextState = DONE;
        end
      end
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      r_base    <= '0;
      r_lastD   <= 1'b1;
      r_servedD <= 1'b0;
    end else if (w_grantI) begin
      r_base    <= lineAlign(i_addr, IOFF_W);
      r_lastD   <= 1'b0;
      r_servedD <= 1'b0;
    end else if (w_grantD) begin
      r_base    <= lineAlign(d_addr, DOFF_W);
      r_lastD   <= 1'b1;
      r_servedD <= 1'b1;
    end
  end

  // Clearing in DONE as well keeps the beat outputs at zero while idle.
  assign w_xfer  = (r_state == I_XFER) || (r_state == D_XFER);
  assign w_last  = r_servedD ? D_LAST : I_LAST;
  assign w_clear = w_grantI || w_grantD || (r_state == DONE);
  assign w_inc   = w_xfer && mem_ready;

  burst_counter #(.W(BEAT_W)) u_beatCounter (
    .clk     (clk),
    .RST     (RST),
    .i_clear (w_clear),
    .i_inc   (w_inc),
    .i_last  (w_last),
    .o_count (w_count),
    .o_tc    (w_tc)
  );

  assign i_gnt  = (r_state == I_XFER) || ((r_state == DONE) && !r_servedD);
  assign d_gnt  = (r_state == D_XFER) || ((r_state == DONE) && r_servedD);
  assign i_done = (r_state == DONE) && !r_servedD;
  assign d_done = (r_state == DONE) && r_servedD;

  assign mem_rd    = (r_state == I_XFER) || ((r_state == D_XFER) && !d_we);
  assign mem_wr    = (r_state == D_XFER) && d_we;
  assign mem_addr  = w_xfer ? (r_base + (32'(w_count) << 2)) : 32'd0;
  assign mem_wdata = d_wdata;

  assign i_rvalid = (r_state == I_XFER) && mem_rd && mem_ready;
  assign d_rvalid = (r_state == D_XFER) && mem_rd && mem_ready;
  assign i_rdata  = mem_rdata;
  assign d_rdata  = mem_rdata;
  assign i_beat   = i_gnt ? w_count : 3'd0;
  assign d_beat   = d_gnt ? w_count[1:0] : 2'd0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed line transfers push expected
// beats/done pulses into a queue that a negedge monitor drains and compares.
module tb_mem_arbiter;

  localparam int EV_NONE  = 0;
  localparam int EV_IRD   = 1;
  localparam int EV_DRD   = 2;
  localparam int EV_DWR   = 3;
  localparam int EV_IDONE = 4;
  localparam int EV_DDONE = 5;

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [31:0] beat;
    logic [31:0] data;
  } ev_t;

  logic        clk = 1'b0;
  logic        RST;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic [2:0]  i_beat;
  logic        i_done;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic        d_done;
  logic [31:0] d_rdata;
  logic [1:0]  d_beat;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  ev_t expQ[$];
  int  vectors;
  int  miscompares;
  bit  bothGnt;
  int  monKind;
  ev_t monEv;

  always #5 clk = ~clk;

  // Memory returns an address-derived word; the D-cache supplies a beat-tagged word.
  assign mem_rdata = mem_addr ^ 32'hA5A5_0000;
  assign d_wdata   = 32'hC0DE_0000 | 32'(d_beat);

  mem_arbiter dut (
    .clk       (clk),
    .RST       (RST),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_gnt     (i_gnt),
    .i_rvalid  (i_rvalid),
    .i_rdata   (i_rdata),
    .i_beat    (i_beat),
    .i_done    (i_done),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_done    (d_done),
    .d_rdata   (d_rdata),
    .d_beat    (d_beat),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: actual 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input bit isD, input bit we, input logic [31:0] addr,
                               input logic [31:0] base, input int nBeats,
                               input bit withDone, input bit assertReq);
    ev_t e;
    for (int b = 0; b < nBeats; b++) begin
      e.kind = isD ? (we ? EV_DWR : EV_DRD) : EV_IRD;
      e.addr = base + 32'(4 * b);
      e.beat = 32'(b);
      e.data = (isD && we) ? (32'hC0DE_0000 | 32'(b)) : ((base + 32'(4 * b)) ^ 32'hA5A5_0000);
      expQ.push_back(e);
    end
    if (withDone) begin
      e.kind = isD ? EV_DDONE : EV_IDONE;
      e.addr = '0;
      e.beat = '0;
      e.data = '0;
      expQ.push_back(e);
    end
    if (isD) begin
      d_addr = addr;
      d_we   = we;
      if (assertReq) d_req = 1'b1;
    end else begin
      i_addr = addr;
      if (assertReq) i_req = 1'b1;
    end
  endtask

  // Entered in the IDLE cycle where the request is already high (cycle 1).
  task automatic runTransfer(input bit isD, input logic [31:0] base, input int words,
                             input int waits, input int lateAt, input int expCycles,
                             input string tag);
    int cycles;
    int k;
    int beat;
    bit seenDone;
    bit sawOther;
    cycles   = 1;
    k        = 0;
    seenDone = 1'b0;
    sawOther = 1'b0;
    while (!seenDone && cycles < 300) begin
      k = cycles - 2;
      if (waits == 0) mem_ready = 1'b1;
      else mem_ready = (k >= 0) && ((k % (waits + 1)) == waits);
      if (lateAt == cycles) d_req = 1'b1;
      @(negedge clk);
      if (isD ? i_gnt : d_gnt) sawOther = 1'b1;
      if (waits > 0 && !mem_ready && k >= 0 && k < words * (waits + 1)) begin
        beat = k / (waits + 1);
        checkOutput({tag, " hold addr"}, mem_addr, base + 32'(4 * beat));
        checkOutput({tag, " hold beat"}, isD ? 32'(d_beat) : 32'(i_beat), 32'(beat));
      end
      if (isD ? d_done : i_done) begin
        seenDone = 1'b1;
        checkOutput({tag, " done strobes"}, 32'({mem_rd, mem_wr}), 32'd0);
        checkOutput({tag, " done gnt"}, 32'(isD ? d_gnt : i_gnt), 32'd1);
      end else begin
        @(posedge clk);
        #1;
        cycles++;
      end
    end
    checkOutput({tag, " done cycle"}, 32'(cycles), 32'(expCycles));
    checkOutput({tag, " other gnt"}, 32'(sawOther), 32'd0);
    @(posedge clk);
    #1;
    if (isD) d_req = 1'b0;
    else i_req = 1'b0;
  endtask

  // Every beat or done pulse the DUT presents must match the next queued entry.
  always @(negedge clk) begin
    if (i_gnt && d_gnt) bothGnt = 1'b1;
    monKind = EV_NONE;
    if (i_rvalid) monKind = EV_IRD;
    else if (d_rvalid) monKind = EV_DRD;
    else if (mem_wr && mem_ready) monKind = EV_DWR;
    else if (i_done) monKind = EV_IDONE;
    else if (d_done) monKind = EV_DDONE;
    if (monKind != EV_NONE) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected event", 32'(monKind), 32'(EV_NONE));
      end else begin
        monEv = expQ.pop_front();
        checkOutput("event kind", 32'(monKind), 32'(monEv.kind));
        if (monKind == EV_IRD) begin
          checkOutput("I addr", mem_addr, monEv.addr);
          checkOutput("I beat", 32'(i_beat), monEv.beat);
          checkOutput("I rdata", i_rdata, monEv.data);
        end else if (monKind == EV_DRD) begin
          checkOutput("D addr", mem_addr, monEv.addr);
          checkOutput("D beat", 32'(d_beat), monEv.beat);
          checkOutput("D rdata", d_rdata, monEv.data);
        end else if (monKind == EV_DWR) begin
          checkOutput("WB addr", mem_addr, monEv.addr);
          checkOutput("WB beat", 32'(d_beat), monEv.beat);
          checkOutput("WB wdata", mem_wdata, monEv.data);
          checkOutput("WB mem_rd", 32'(mem_rd), 32'd0);
        end
      end
    end
  end

  initial begin
    RST         = 1'b1;
    i_req       = 1'b0;
    d_req       = 1'b0;
    d_we        = 1'b0;
    i_addr      = '0;
    d_addr      = '0;
    mem_ready   = 1'b0;
    vectors     = 0;
    miscompares = 0;
    bothGnt     = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    RST = 1'b0;
    @(negedge clk);
    checkOutput("reset ctrl",
                32'({i_gnt, d_gnt, i_rvalid, d_rvalid, i_done, d_done, mem_rd, mem_wr, i_beat, d_beat}),
                32'd0);
    checkOutput("reset mem_addr", mem_addr, 32'd0);
    @(posedge clk);
    #1;

    $display("[TB] I-side refill");
    applyStimulus(1'b0, 1'b0, 32'h0000_1034, 32'h0000_1020, 8, 1'b1, 1'b1);
    runTransfer(1'b0, 32'h0000_1020, 8, 0, 0, 10, "irefill");

    $display("[TB] tie with I served last");
    applyStimulus(1'b1, 1'b0, 32'h0000_301C, 32'h0000_3010, 4, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'h0000_405C, 32'h0000_4040, 8, 1'b1, 1'b1);
    runTransfer(1'b1, 32'h0000_3010, 4, 0, 0, 6, "tieA-D");
    runTransfer(1'b0, 32'h0000_4040, 8, 0, 0, 10, "tieA-I");

    $display("[TB] D-side writeback");
    applyStimulus(1'b1, 1'b1, 32'h0000_2008, 32'h0000_2000, 4, 1'b1, 1'b1);
    runTransfer(1'b1, 32'h0000_2000, 4, 0, 0, 6, "wback");

    $display("[TB] D-side refill with wait states");
    applyStimulus(1'b1, 1'b0, 32'h0000_5004, 32'h0000_5000, 4, 1'b1, 1'b1);
    runTransfer(1'b1, 32'h0000_5000, 4, 3, 0, 18, "dwait");

    $display("[TB] reset during I-side beat 3");
    applyStimulus(1'b0, 1'b0, 32'h0000_8000, 32'h0000_8000, 4, 1'b0, 1'b1);
    mem_ready = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    RST = 1'b1;
    @(posedge clk);
    #1;
    RST   = 1'b0;
    i_req = 1'b0;
    @(negedge clk);
    checkOutput("abort ctrl", 32'({mem_rd, mem_wr, i_gnt, d_gnt, i_done}), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("abort idle strobes", 32'({mem_rd, mem_wr}), 32'd0);
    @(posedge clk);
    #1;

    $display("[TB] ties after reset");
    applyStimulus(1'b0, 1'b0, 32'h0000_9010, 32'h0000_9000, 8, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 32'h0000_A00C, 32'h0000_A000, 4, 1'b1, 1'b1);
    runTransfer(1'b0, 32'h0000_9000, 8, 0, 0, 10, "tieB-I");
    runTransfer(1'b1, 32'h0000_A000, 4, 0, 0, 6, "tieB-D");
    applyStimulus(1'b0, 1'b0, 32'h0000_B0E4, 32'h0000_B0E0, 8, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 32'h0000_C000, 32'h0000_C000, 4, 1'b1, 1'b1);
    runTransfer(1'b0, 32'h0000_B0E0, 8, 0, 0, 10, "tieC-I");
    runTransfer(1'b1, 32'h0000_C000, 4, 0, 0, 6, "tieC-D");

    $display("[TB] late D request during I transfer");
    applyStimulus(1'b0, 1'b0, 32'h0000_6000, 32'h0000_6000, 8, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 32'h0000_7008, 32'h0000_7000, 4, 1'b1, 1'b0);
    runTransfer(1'b0, 32'h0000_6000, 8, 0, 4, 10, "late-I");
    runTransfer(1'b1, 32'h0000_7000, 4, 0, 0, 6, "late-D");

    repeat (3) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    #1;
    checkOutput("pending events", 32'(expQ.size()), 32'd0);
    checkOutput("gnt exclusive", 32'(bothGnt), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
